// File: rtl/axi_bridge_arb.sv
// Round-robin arbiter bridging N_CH single-beat request channels onto one AXI4-Lite master.
// One transaction is in flight at a time; completions return to the granted channel.
module axi_bridge_arb #(
    parameter int N_CH   = 2,
    parameter int ADDR_W = 17,
    parameter int DATA_W = 64
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_CH-1:0]          C_in_valid,
    input  logic [N_CH-1:0]          C_r_wb,
    input  logic [N_CH*ADDR_W-1:0]   C_addr,
    input  logic [N_CH*DATA_W-1:0]   C_data_w,
    output logic [N_CH-1:0]          C_busy,
    output logic [N_CH-1:0]          C_out_valid,
    output logic [N_CH-1:0]          C_err,
    output logic [DATA_W-1:0]        C_data_r,
    output logic                     AR_VALID,
    input  logic                     AR_READY,
    output logic [ADDR_W-1:0]        AR_ADDR,
    input  logic                     R_VALID,
    output logic                     R_READY,
    input  logic [DATA_W-1:0]        R_DATA,
    input  logic [1:0]               R_RESP,
    output logic                     AW_VALID,
    input  logic                     AW_READY,
    output logic [ADDR_W-1:0]        AW_ADDR,
    output logic                     W_VALID,
    input  logic                     W_READY,
    output logic [DATA_W-1:0]        W_DATA,
    input  logic                     B_VALID,
    output logic                     B_READY,
    input  logic [1:0]               B_RESP,
    output logic [2:0]               dbg_state
);
    localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_AR   = 3'd1,
        S_R    = 3'd2,
        S_AW   = 3'd3,
        S_W    = 3'd4,
        S_B    = 3'd5,
        S_RSP  = 3'd6
    } state_t;

    state_t              state_q, state_d;
    logic [N_CH-1:0]     pend_q, pend_d;
    logic [N_CH-1:0]     rw_q, rw_d;
    logic [ADDR_W-1:0]   addr_q [N_CH];
    logic [ADDR_W-1:0]   addr_d [N_CH];
    logic [DATA_W-1:0]   data_q [N_CH];
    logic [DATA_W-1:0]   data_d [N_CH];
    logic [CH_W-1:0]     g_q, g_d;
    logic [CH_W-1:0]     last_q, last_d;
    logic [1:0]          resp_q, resp_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;

    logic                arb_found;
    logic [CH_W-1:0]     arb_idx;
    logic [CH_W-1:0]     cand;
    logic [N_CH-1:0]     g_onehot;

    // Search starts one past the last grant so every pending channel is reached within N_CH grants.
    always_comb begin
        arb_found = 1'b0;
        arb_idx   = '0;
        cand      = '0;
        for (int k = 1; k <= N_CH; k++) begin
            cand = CH_W'((int'(last_q) + k) % N_CH);
            if (!arb_found && pend_q[cand]) begin
                arb_found = 1'b1;
                arb_idx   = cand;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        pend_d  = pend_q;
        rw_d    = rw_q;
        addr_d  = addr_q;
        data_d  = data_q;
        g_d     = g_q;
        last_d  = last_q;
        resp_d  = resp_q;
        rdata_d = rdata_q;

        for (int i = 0; i < N_CH; i++) begin
            if (C_in_valid[i] && !pend_q[i]) begin
                pend_d[i] = 1'b1;
                rw_d[i]   = C_r_wb[i];
                addr_d[i] = C_addr[i*ADDR_W +: ADDR_W];
                data_d[i] = C_data_w[i*DATA_W +: DATA_W];
            end
        end

        // AXI handshake: a valid stays high with stable payload until the matching ready is sampled.
        case (state_q)
            S_IDLE: begin
                if (arb_found) begin
                    g_d     = arb_idx;
                    last_d  = arb_idx;
                    resp_d  = 2'b00;
                    rdata_d = '0;
                    state_d = rw_q[arb_idx] ? S_AR : S_AW;
                end
            end
            S_AR: if (AR_READY) state_d = S_R;
            S_R: begin
                if (R_VALID) begin
                    rdata_d = R_DATA;
                    resp_d  = R_RESP;
                    state_d = S_RSP;
                end
            end
            S_AW: if (AW_READY) state_d = S_W;
            S_W:  if (W_READY)  state_d = S_B;
            S_B: begin
                if (B_VALID) begin
                    resp_d  = B_RESP;
                    state_d = S_RSP;
                end
            end
            S_RSP: begin
                pend_d[g_q] = 1'b0;
                state_d     = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            pend_q  <= '0;
            rw_q    <= '0;
            addr_q  <= '{default: '0};
            data_q  <= '{default: '0};
            g_q     <= '0;
            last_q  <= CH_W'(N_CH - 1);
            resp_q  <= 2'b00;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            rw_q    <= rw_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            g_q     <= g_d;
            last_q  <= last_d;
            resp_q  <= resp_d;
            rdata_q <= rdata_d;
        end
    end

    assign g_onehot    = N_CH'(1) << g_q;
    assign C_busy      = pend_q;
    assign C_out_valid = (state_q == S_RSP) ? g_onehot : '0;
    assign C_err       = (state_q == S_RSP && resp_q != 2'b00) ? g_onehot : '0;
    assign C_data_r    = rdata_q;
    assign AR_VALID    = (state_q == S_AR);
    assign AR_ADDR     = (state_q == S_AR) ? addr_q[g_q] : '0;
    assign R_READY     = (state_q == S_R);
    assign AW_VALID    = (state_q == S_AW);
    assign AW_ADDR     = (state_q == S_AW) ? addr_q[g_q] : '0;
    assign W_VALID     = (state_q == S_W);
    assign W_DATA      = (state_q == S_W) ? data_q[g_q] : '0;
    assign B_READY     = (state_q == S_B);
    assign dbg_state   = state_q;
endmodule

// File: tb/tb_axi_bridge_arb.sv
// Bench for axi_bridge_arb: pseudo-DRAM responder, request driver, scoreboard with expected queue.
module tb_axi_bridge_arb;
    localparam int NC = 4;
    localparam int AW = 17;
    localparam int DW = 64;

    logic             clk = 1'b0;
    logic             rst;
    logic [NC-1:0]    C_in_valid, C_r_wb;
    logic [NC*AW-1:0] C_addr;
    logic [NC*DW-1:0] C_data_w;
    logic [NC-1:0]    C_busy, C_out_valid, C_err;
    logic [DW-1:0]    C_data_r;
    logic             AR_VALID, AR_READY, R_VALID, R_READY;
    logic [AW-1:0]    AR_ADDR, AW_ADDR;
    logic [DW-1:0]    R_DATA, W_DATA;
    logic [1:0]       R_RESP, B_RESP;
    logic             AW_VALID, AW_READY, W_VALID, W_READY, B_VALID, B_READY;
    logic [2:0]       dbg_state;

    axi_bridge_arb #(.N_CH(NC), .ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .rst(rst),
        .C_in_valid(C_in_valid), .C_r_wb(C_r_wb), .C_addr(C_addr), .C_data_w(C_data_w),
        .C_busy(C_busy), .C_out_valid(C_out_valid), .C_err(C_err), .C_data_r(C_data_r),
        .AR_VALID(AR_VALID), .AR_READY(AR_READY), .AR_ADDR(AR_ADDR),
        .R_VALID(R_VALID), .R_READY(R_READY), .R_DATA(R_DATA), .R_RESP(R_RESP),
        .AW_VALID(AW_VALID), .AW_READY(AW_READY), .AW_ADDR(AW_ADDR),
        .W_VALID(W_VALID), .W_READY(W_READY), .W_DATA(W_DATA),
        .B_VALID(B_VALID), .B_READY(B_READY), .B_RESP(B_RESP),
        .dbg_state(dbg_state)
    );

    // ---------------- clock / reset / cycle count ----------------
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- reference memory and DRAM contents ----------------
    logic [DW-1:0] dram  [logic [AW-1:0]];
    logic [DW-1:0] mem_m [logic [AW-1:0]];

    function automatic logic [DW-1:0] init_val(input logic [AW-1:0] a);
        return {16'hA5C3, 15'h0, a, 16'h0F0F};
    endfunction

    function automatic logic [1:0] err_of(input logic [AW-1:0] a);
        return (a[6:3] == 4'hF) ? 2'b10 : 2'b00;
    endfunction

    function automatic logic [DW-1:0] dram_rd(input logic [AW-1:0] a);
        return dram.exists(a) ? dram[a] : init_val(a);
    endfunction

    function automatic logic [DW-1:0] mem_rd(input logic [AW-1:0] a);
        return mem_m.exists(a) ? mem_m[a] : init_val(a);
    endfunction

    function automatic logic [AW-1:0] ch_addr(input int ch, input int w);
        return {2'(ch), 8'h00, 4'(w), 3'b000};
    endfunction

    // ---------------- pseudo-DRAM responder ----------------
    int ar_dly = 0, r_dly = 0, aw_dly = 0, w_dly = 0, b_dly = 0;
    int ar_cnt = 0, r_cnt = 0, aw_cnt = 0, w_cnt = 0, b_cnt = 0;
    logic [AW-1:0] rd_addr = '0, wr_addr = '0;

    initial begin
        AR_READY = 0; R_VALID = 0; R_DATA = '0; R_RESP = 2'b00;
        AW_READY = 0; W_READY = 0; B_VALID = 0; B_RESP = 2'b00;
        forever begin
            @(posedge clk);
            #2;
            if (rst) begin
                AR_READY = 0; R_VALID = 0; AW_READY = 0; W_READY = 0; B_VALID = 0;
                ar_cnt = 0; r_cnt = 0; aw_cnt = 0; w_cnt = 0; b_cnt = 0;
            end else begin
                if (AR_VALID) begin AR_READY = (ar_cnt >= ar_dly); ar_cnt++; end
                else begin AR_READY = 0; ar_cnt = 0; end
                if (AW_VALID) begin AW_READY = (aw_cnt >= aw_dly); aw_cnt++; end
                else begin AW_READY = 0; aw_cnt = 0; end
                if (W_VALID) begin W_READY = (w_cnt >= w_dly); w_cnt++; end
                else begin W_READY = 0; w_cnt = 0; end
                if (R_READY) begin
                    R_VALID = (r_cnt >= r_dly);
                    R_DATA  = dram_rd(rd_addr);
                    R_RESP  = err_of(rd_addr);
                    r_cnt++;
                end else begin R_VALID = 0; r_cnt = 0; end
                if (B_READY) begin
                    B_VALID = (b_cnt >= b_dly);
                    B_RESP  = err_of(wr_addr);
                    b_cnt++;
                end else begin B_VALID = 0; b_cnt = 0; end
            end
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            if (AR_VALID && AR_READY) rd_addr = AR_ADDR;
            if (AW_VALID && AW_READY) wr_addr = AW_ADDR;
            if (W_VALID && W_READY && err_of(wr_addr) == 2'b00) dram[wr_addr] = W_DATA;
        end
    end

    // ---------------- scoreboard state ----------------
    typedef struct {
        int            ch;
        bit            rw;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [DW-1:0] rdata;
        bit            err;
        int            issue;
        int            lat;
    } exp_t;

    exp_t          exp_q[$];
    int            ord_q[$];
    exp_t          stage [NC];
    logic [NC-1:0] busy_m   = '0;
    logic [NC-1:0] pend_acc = '0;
    int            last_done = NC - 1;
    int            comp_cnt  = 0;
    bit            mon_en    = 0;

    function automatic int find_ch(input int ch);
        foreach (exp_q[i]) if (exp_q[i].ch == ch) return i;
        return -1;
    endfunction

    function automatic int find_addr(input bit rw, input logic [AW-1:0] a);
        foreach (exp_q[i]) if (exp_q[i].rw == rw && exp_q[i].addr == a) return i;
        return -1;
    endfunction

    // ---------------- monitor ----------------
    logic          p_ar_v = 0, p_ar_r = 0, p_aw_v = 0, p_aw_r = 0, p_w_v = 0, p_w_r = 0, p_rst = 1;
    logic [AW-1:0] p_ar_a = '0, p_aw_a = '0, aw_seen = '0;
    logic [DW-1:0] p_w_d = '0;
    int            m_ch, m_idx;
    exp_t          m_e;

    always @(negedge clk) begin
        if (mon_en) begin
            check("busy", C_busy, busy_m);
            if (C_out_valid != '0) begin
                check("out_onehot", $onehot(C_out_valid), 1);
                m_ch = 0;
                for (int i = 0; i < NC; i++) if (C_out_valid[i]) m_ch = i;
                m_idx = find_ch(m_ch);
                check("completion_expected", m_idx >= 0, 1);
                if (m_idx >= 0) begin
                    m_e = exp_q[m_idx];
                    check("data_r", C_data_r, m_e.rw ? m_e.rdata : 64'h0);
                    check("err", C_err, m_e.err ? (NC'(1) << m_ch) : NC'(0));
                    if (m_e.lat >= 0) check("latency", cyc - m_e.issue, m_e.lat);
                    if (!m_e.rw && !m_e.err) mem_m[m_e.addr] = m_e.wdata;
                    exp_q.delete(m_idx);
                    busy_m[m_ch] = 1'b0;
                end
                if (ord_q.size() > 0) check("grant_order", m_ch, ord_q.pop_front());
                last_done = m_ch;
                comp_cnt++;
            end else begin
                check("err_idle", C_err, '0);
            end
            if (AR_VALID && AR_READY) check("ar_addr_known", find_addr(1'b1, AR_ADDR) >= 0, 1);
            if (AW_VALID && AW_READY) begin
                check("aw_addr_known", find_addr(1'b0, AW_ADDR) >= 0, 1);
                aw_seen = AW_ADDR;
            end
            if (W_VALID && W_READY) begin
                m_idx = find_addr(1'b0, aw_seen);
                check("w_data", W_DATA, (m_idx >= 0) ? exp_q[m_idx].wdata : ~W_DATA);
            end
            if (!p_rst) begin
                if (p_ar_v && !p_ar_r) check("ar_hold", {AR_VALID, AR_ADDR}, {1'b1, p_ar_a});
                if (p_aw_v && !p_aw_r) check("aw_hold", {AW_VALID, AW_ADDR}, {1'b1, p_aw_a});
                if (p_w_v && !p_w_r)   check("w_hold", {W_VALID, W_DATA[62:0]}, {1'b1, p_w_d[62:0]});
            end
        end
        p_ar_v = AR_VALID; p_ar_r = AR_READY; p_ar_a = AR_ADDR;
        p_aw_v = AW_VALID; p_aw_r = AW_READY; p_aw_a = AW_ADDR;
        p_w_v = W_VALID; p_w_r = W_READY; p_w_d = W_DATA;
        p_rst = rst;
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
        for (int i = 0; i < NC; i++) begin
            if (pend_acc[i]) begin
                busy_m[i] = 1'b1;
                exp_q.push_back(stage[i]);
            end
        end
        pend_acc   = '0;
        C_in_valid = '0;
    endtask

    task automatic req(input int ch, input bit rw, input logic [AW-1:0] a, input logic [DW-1:0] d,
                       input int lat);
        C_in_valid[ch]         = 1'b1;
        C_r_wb[ch]             = rw;
        C_addr[ch*AW +: AW]    = a;
        C_data_w[ch*DW +: DW]  = d;
        if (!busy_m[ch] && !pend_acc[ch]) begin
            pend_acc[ch] = 1'b1;
            stage[ch] = '{ch: ch, rw: rw, addr: a, wdata: d, rdata: mem_rd(a),
                          err: (err_of(a) != 2'b00), issue: cyc, lat: lat};
        end
    endtask

    task automatic batch(input logic [NC-1:0] mask, input bit rw);
        for (int k = 1; k <= NC; k++) begin
            if (mask[(last_done + k) % NC]) ord_q.push_back((last_done + k) % NC);
        end
        for (int c = 0; c < NC; c++) begin
            if (mask[c]) req(c, rw, ch_addr(c, $urandom_range(0, 14)), {$urandom, $urandom}, -1);
        end
    endtask

    task automatic wait_idle(input int max);
        int n = 0;
        while ((busy_m != '0 || pend_acc != '0 || exp_q.size() != 0) && n < max) begin
            tick();
            n++;
        end
        check("idle_timeout", (busy_m != '0 || pend_acc != '0 || exp_q.size() != 0), 0);
        check("order_drained", ord_q.size(), 0);
        ord_q.delete();
    endtask

    task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] d);
        dram[a]  = d;
        mem_m[a] = d;
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int c0;
        int n;
        rst = 1'b1;
        C_in_valid = '0; C_r_wb = '0; C_addr = '0; C_data_w = '0;
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst_busy", C_busy, 0);
        check("rst_out_valid", C_out_valid, 0);
        check("rst_err", C_err, 0);
        check("rst_data_r", C_data_r, 0);
        check("rst_ar_valid", AR_VALID, 0);
        check("rst_aw_valid", AW_VALID, 0);
        check("rst_w_valid", W_VALID, 0);
        check("rst_r_ready", R_READY, 0);
        check("rst_b_ready", B_READY, 0);
        check("rst_ar_addr", AR_ADDR, 0);
        check("rst_w_data", W_DATA, 0);
        check("rst_state", dbg_state, 0);
        mon_en = 1'b1;

        // simultaneous pair straight after reset: ch0 then ch1
        tick(); batch(4'b0011, 1'b1);
        wait_idle(50);

        // single zero-wait read, 4-cycle latency
        preload(17'h10000, 64'hDEAD_BEEF_0123_4567);
        tick(); req(0, 1'b1, 17'h10000, '0, 4);
        wait_idle(50);

        // all channels repeatedly, then a rotated start
        tick(); batch(4'b1111, 1'b1); wait_idle(100);
        tick(); batch(4'b1111, 1'b0); wait_idle(100);
        tick(); req(1, 1'b1, ch_addr(1, 2), '0, 4); wait_idle(50);
        tick(); batch(4'b1111, 1'b1); wait_idle(100);

        // zero-wait write, then write with DRAM waits AW 3 / W 2 / B 5
        tick(); req(3, 1'b0, ch_addr(3, 5), 64'h0BAD_F00D_CAFE_0001, 5); wait_idle(50);
        aw_dly = 3; w_dly = 2; b_dly = 5;
        tick(); req(0, 1'b0, ch_addr(0, 6), 64'h1234_5678_9ABC_DEF0, 15); wait_idle(100);
        aw_dly = 0; w_dly = 0; b_dly = 0;
        tick(); req(0, 1'b1, ch_addr(0, 6), '0, 4); wait_idle(50);

        // error responses on read and write
        tick(); req(2, 1'b1, ch_addr(2, 15), '0, 4); wait_idle(50);
        tick(); req(3, 1'b0, ch_addr(3, 15), 64'h5555_AAAA_5555_AAAA, 5); wait_idle(50);
        tick(); req(3, 1'b1, ch_addr(3, 15), '0, 4); wait_idle(50);

        // duplicate pulses while busy are dropped
        c0 = comp_cnt;
        tick(); req(1, 1'b1, ch_addr(1, 7), '0, 4);
        tick(); req(1, 1'b1, ch_addr(1, 8), '0, -1);
        tick(); req(1, 1'b0, ch_addr(1, 8), 64'hFFFF_0000_FFFF_0000, -1);
        wait_idle(50);
        check("dup_completions", comp_cnt - c0, 1);

        // reset while in W aborts the write silently
        w_dly = 6;
        tick(); req(1, 1'b0, ch_addr(1, 3), 64'h1111_2222_3333_4444, -1);
        n = 0;
        do begin tick(); n++; end while (!W_VALID && n < 20);
        check("reached_w", W_VALID, 1);
        c0 = comp_cnt;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        busy_m = '0; exp_q.delete(); ord_q.delete(); last_done = NC - 1;
        check("abort_w_valid", W_VALID, 0);
        check("abort_busy", C_busy, 0);
        w_dly = 0;
        repeat (8) tick();
        check("abort_no_completion", comp_cnt - c0, 0);
        tick(); req(1, 1'b1, ch_addr(1, 3), '0, 4); wait_idle(50);

        // randomized traffic with varying DRAM waits
        for (int k = 0; k < 400; k++) begin
            tick();
            if ($urandom_range(0, 15) == 0) begin
                ar_dly = $urandom_range(0, 3); r_dly = $urandom_range(0, 3);
                aw_dly = $urandom_range(0, 3); w_dly = $urandom_range(0, 3);
                b_dly = $urandom_range(0, 3);
            end
            for (int c = 0; c < NC; c++) begin
                if ($urandom_range(0, 3) == 0)
                    req(c, 1'($urandom_range(0, 1)), ch_addr(c, $urandom_range(0, 15)),
                        {$urandom, $urandom}, -1);
            end
        end
        wait_idle(1000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        failures++;
        $display("FAIL watchdog: got timeout expected completion of sequence");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
